// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage register.
//   ST_EMPTY / ST_ONE / ST_TWO : stage occupancy states, also the occupancy value
//   pipe_state_t               : 2-bit state type
//   MIPS_NOP                   : all-zero instruction word used as the bubble
package pipe_pkg;

    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_ONE   = 2'd1;
    localparam pipe_state_t ST_TWO   = 2'd2;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter for performance events.
//   CLK   : clock
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (rst)
            r_count <= '0;
        else if (inc && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage with optional skid entry,
// field-preserving flush and a saturating stall counter.
//   CLK, rst            : clock, synchronous active-high reset
//   flush               : kill contents, load bubble merged with kept in_data fields
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload (main entry)
//   occupancy           : entries held (0..2), equals the state encoding
//   stall_cnt           : cycles with out_valid & !out_ready, saturating
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter bit               SKID      = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE    = '0,
    parameter logic [WIDTH-1:0] KEEP_MASK = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      r_state, w_nxt_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_in_ready, w_out_valid;
    logic             w_accept, w_drain;
    logic             w_load_main_in, w_load_main_skid, w_load_skid;

    // With a skid entry, in_ready comes straight from the state register so
    // out_ready never reaches upstream combinationally.
    generate
        if (SKID) begin : g_rdy_skid
            assign w_in_ready = (r_state != ST_TWO);
        end else begin : g_rdy_noskid
            assign w_in_ready = (r_state == ST_EMPTY) || out_ready;
        end
    endgenerate

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid && w_in_ready;
    assign w_drain     = w_out_valid && out_ready;

    // State register
    always_ff @(posedge CLK) begin
        if (rst || flush)
            r_state <= ST_EMPTY;
        else
            r_state <= w_nxt_state;
    end

    // Next-state logic. Without a skid entry, accept in ONE implies drain,
    // so TWO is never reached.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_nxt_state = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_drain)      w_nxt_state = ST_TWO;
                else if (!w_accept && w_drain) w_nxt_state = ST_EMPTY;
            end
            ST_TWO:   if (w_drain) w_nxt_state = ST_ONE;
            default:  w_nxt_state = ST_EMPTY;
        endcase
    end

    // Datapath load controls
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: w_load_main_in = w_accept;
            ST_ONE: begin
                w_load_main_in = w_accept && w_drain;
                w_load_skid    = w_accept && !w_drain;
            end
            ST_TWO:   w_load_main_skid = w_drain;
            default: ;
        endcase
    end

    // Main entry. A drain without refill leaves the old payload in place.
    always_ff @(posedge CLK) begin
        if (rst)
            r_main <= BUBBLE;
        else if (flush)
            r_main <= (in_data & KEEP_MASK) | (BUBBLE & ~KEEP_MASK);
        else if (w_load_main_in)
            r_main <= in_data;
        else if (w_load_main_skid)
            r_main <= w_skid_data;
    end

    generate
        if (SKID) begin : g_skid
            logic [WIDTH-1:0] r_skid;
            always_ff @(posedge CLK) begin
                if (rst || flush)
                    r_skid <= BUBBLE;
                else if (w_load_skid)
                    r_skid <= in_data;
            end
            assign w_skid_data = r_skid;
        end else begin : g_noskid
            assign w_skid_data = BUBBLE;
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .rst   (rst),
        .inc   (w_out_valid && !out_ready),
        .count (stall_cnt)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam logic [31:0] KEEP = 32'h0000_FFFF;
    localparam logic [31:0] BUB  = 32'h0000_0000;
    localparam int          SMAX = 15;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [1:0]  occ_a, occ_b;
    logic [3:0]  stall_a, stall_b;

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of capacity 2 (dut a, skid) or 1 (dut b).
    int          m_cnt   [2];
    logic [31:0] m_buf   [2][2];
    logic [31:0] m_data  [2];
    int          m_stall [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .BUBBLE(BUB), .KEEP_MASK(KEEP), .CNT_W(4)) u_a (
        .CLK(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occupancy(occ_a), .stall_cnt(stall_a));

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .BUBBLE(BUB), .KEEP_MASK(KEEP), .CNT_W(4)) u_b (
        .CLK(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occ_b), .stall_cnt(stall_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy(input int d);
        if (d == 0) return m_cnt[0] < 2;
        return (m_cnt[1] == 0) || out_ready;
    endfunction

    // Compare every cycle on the falling edge, then advance the model with
    // the inputs the next rising edge will sample.
    initial begin
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_data[d] = BUB; m_stall[d] = 0;
        end
        forever begin
            @(negedge clk);
            chk("a.out_valid", {31'b0, out_valid_a}, {31'b0, m_cnt[0] > 0});
            chk("a.out_data",  out_data_a, m_data[0]);
            chk("a.in_ready",  {31'b0, in_ready_a}, {31'b0, m_rdy(0)});
            chk("a.occupancy", {30'b0, occ_a}, m_cnt[0]);
            chk("a.stall_cnt", {28'b0, stall_a}, m_stall[0]);
            chk("b.out_valid", {31'b0, out_valid_b}, {31'b0, m_cnt[1] > 0});
            chk("b.out_data",  out_data_b, m_data[1]);
            chk("b.in_ready",  {31'b0, in_ready_b}, {31'b0, m_rdy(1)});
            chk("b.occupancy", {30'b0, occ_b}, m_cnt[1]);
            chk("b.stall_cnt", {28'b0, stall_b}, m_stall[1]);
            for (int d = 0; d < 2; d++) begin
                bit acc, drn;
                acc = in_valid && m_rdy(d);
                drn = (m_cnt[d] > 0) && out_ready;
                if (rst) begin
                    m_cnt[d] = 0; m_data[d] = BUB; m_stall[d] = 0;
                end else begin
                    if (m_cnt[d] > 0 && !out_ready && m_stall[d] < SMAX) m_stall[d]++;
                    if (flush) begin
                        m_cnt[d]  = 0;
                        m_data[d] = (in_data & KEEP) | (BUB & ~KEEP);
                    end else begin
                        if (drn) begin m_buf[d][0] = m_buf[d][1]; m_cnt[d]--; end
                        if (acc) begin m_buf[d][m_cnt[d]] = in_data; m_cnt[d]++; end
                        if (m_cnt[d] > 0) m_data[d] = m_buf[d][0];
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;

        // Reset held two cycles with a valid payload presented
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst.out_valid", {31'b0, out_valid_a}, 0);
            chk("rst.out_data",  out_data_a, 32'h0);
            chk("rst.occupancy", {30'b0, occ_a}, 0);
            chk("rst.in_ready",  {31'b0, in_ready_a}, 1);
            chk("rst.stall_cnt", {28'b0, stall_a}, 0);
        end
        chk("model.rst_cnt", m_cnt[0], 0);
        rst = 1'b0; in_valid = 1'b0;

        // Back-to-back streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick;
            chk("stream.out_valid", {31'b0, out_valid_a}, 1);
            chk("stream.out_data",  out_data_a, i);
            chk("stream.in_ready",  {31'b0, in_ready_a}, 1);
        end
        in_valid = 1'b0;
        tick;
        chk("stream.empty", {31'b0, out_valid_a}, 0);
        chk("stream.hold_data", out_data_a, 32'h8);
        chk("model.stream_data", m_data[0], 32'h8);

        // Backpressure into TWO, then ordered delivery
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        tick;
        in_data = 32'hB;
        tick;
        in_valid = 1'b0;
        chk("bp.occupancy", {30'b0, occ_a}, 2);
        chk("bp.in_ready",  {31'b0, in_ready_a}, 0);
        chk("bp.head",      out_data_a, 32'hA);
        chk("model.bp_cnt", m_cnt[0], 2);
        tick;
        out_ready = 1'b1;
        tick;
        chk("bp.second",    out_data_a, 32'hB);
        chk("bp.occ1",      {30'b0, occ_a}, 1);
        tick;
        chk("bp.occ0",      {30'b0, occ_a}, 0);

        // Flush from TWO keeps the low half of in_data
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1;
        tick;
        in_data = 32'h2;
        tick;
        chk("fl.two", {30'b0, occ_a}, 2);
        flush = 1'b1; in_data = 32'h1234_5678;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl.out_valid", {31'b0, out_valid_a}, 0);
        chk("fl.out_data",  out_data_a, 32'h0000_5678);
        chk("fl.occupancy", {30'b0, occ_a}, 0);
        chk("fl.in_ready",  {31'b0, in_ready_a}, 1);
        chk("model.fl_data", m_data[0], 32'h0000_5678);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("fl.no_stale", {31'b0, out_valid_a}, 0);
        end

        // Stall counter saturation, survives flush, cleared by reset
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77;
        tick;
        in_valid = 1'b0;
        repeat (20) tick;
        chk("sat.a", {28'b0, stall_a}, 15);
        chk("sat.b", {28'b0, stall_b}, 15);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("sat.flush", {28'b0, stall_a}, 15);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("sat.rst_a", {28'b0, stall_a}, 0);
        chk("sat.rst_b", {28'b0, stall_b}, 0);

        // Single-entry stage: combinational in_ready, full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 100 + i;
            #1;
            chk("ns.in_ready", {31'b0, in_ready_b}, 1);
            tick;
            chk("ns.out_valid", {31'b0, out_valid_b}, 1);
            chk("ns.out_data",  out_data_b, 100 + i);
        end
        in_valid = 1'b0;

        // Reset while holding data
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h55;
        tick;
        in_valid = 1'b0;
        chk("rmid.held", {31'b0, out_valid_b}, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rmid.out_valid", {31'b0, out_valid_b}, 0);
        chk("rmid.out_data",  out_data_b, 32'h0);
        chk("rmid.occ_a",     {30'b0, occ_a}, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rmid.no_stale", {31'b0, out_valid_b | out_valid_a}, 0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom % 60) == 0;
            flush     = ($urandom % 20) == 0;
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 4) != 0;
            in_data   = $urandom;
            tick;
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
